// File: rtl/mac_tx_arb.sv
// mac_tx_arb: merges N_CH client TX handshakes onto one MAC TX port.
// Ports: clk, rst (async, active-high).
// Per client: cli_rdy_i, cli_strm_i, cli_meta_i, cli_req_o, cli_ack_o, cli_done_o.
// To the MAC: mac_rdy_o, mac_strm_o, mac_meta_o, mac_req_i, mac_ack_i, mac_done_i.
// Status: grant_idx_o, abort_o, grant_cnt_o (16 bits per channel, channel 0 in the LSBs).
// Stream beat layout: {dat[7:0], val, sof, eof, err}, 12 bits per channel.
module mac_tx_arb #(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 2048,
  parameter int GAP      = 2,
  parameter int META_W   = 112
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            cli_rdy_i,
  input  logic [N_CH*12-1:0]         cli_strm_i,
  input  logic [N_CH*META_W-1:0]     cli_meta_i,
  output logic [N_CH-1:0]            cli_req_o,
  output logic [N_CH-1:0]            cli_ack_o,
  output logic [N_CH-1:0]            cli_done_o,
  output logic                       mac_rdy_o,
  output logic [11:0]                mac_strm_o,
  output logic [META_W-1:0]          mac_meta_o,
  input  logic                       mac_req_i,
  input  logic                       mac_ack_i,
  input  logic                       mac_done_i,
  output logic [$clog2(N_CH)-1:0]    grant_idx_o,
  output logic                       abort_o,
  output logic [N_CH*16-1:0]         grant_cnt_o
);

  localparam int GW = $clog2(N_CH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW:0]   NCH_L    = (GW+1)'(N_CH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'((GAP > 0) ? GAP - 1 : 0);
  // Forced terminator: dat 0, val 1, sof 0, eof 1, err 1.
  localparam logic [11:0]   ABORT_BEAT = 12'h00B;

  typedef enum logic [2:0] {ARB, OFFER, XFER, WAITD, GAP_S} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [META_W-1:0]   meta_q, meta_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [PW-1:0]       gap_q, gap_d;
  logic [N_CH-1:0]     ack_q, ack_d;
  logic [N_CH-1:0]     done_q, done_d;
  logic [15:0]         cnt_q [N_CH];
  logic [15:0]         cnt_d [N_CH];

  logic [N_CH-1:0]     rot;
  logic [GW-1:0]       off, win;
  logic [GW:0]         sum, nxt;
  logic [META_W-1:0]   win_meta;
  logic [11:0]         strm_g;
  logic [N_CH-1:0]     g_oh;
  logic                g_eof;

  // Winner select. Round-robin rotates the request vector so the
  // pointer lands on bit 0, then maps the lowest hit back modulo N_CH.
  always_comb begin
    rot = N_CH'({cli_rdy_i, cli_rdy_i} >> rr_q);
    off = '0;
    for (int j = N_CH - 1; j >= 0; j--)
      if (rot[j]) off = GW'(j);
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= NCH_L) sum = sum - NCH_L;
    win = sum[GW-1:0];
    if (ARB_MODE == 1) begin
      win = '0;
      for (int j = N_CH - 1; j >= 0; j--)
        if (cli_rdy_i[j]) win = GW'(j);
    end
  end

  always_comb begin
    win_meta = '0;
    strm_g   = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (win == GW'(j))
        win_meta = cli_meta_i[j*META_W +: META_W];
      if (grant_q == GW'(j))
        strm_g = cli_strm_i[j*12 +: 12];
    end
    g_oh  = N_CH'(1) << grant_q;
    g_eof = strm_g[3] & strm_g[1];
    nxt   = {1'b0, grant_q} + 1'b1;
    if (nxt >= NCH_L) nxt = '0;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    meta_d     = meta_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    ack_d      = '0;
    done_d     = '0;
    cnt_d      = cnt_q;
    mac_rdy_o  = 1'b0;
    mac_strm_o = '0;
    cli_req_o  = '0;
    abort_o    = 1'b0;
    unique case (state_q)
      ARB: begin
        if (|cli_rdy_i) begin
          grant_d = win;
          meta_d  = win_meta;
          state_d = OFFER;
        end
      end
      OFFER: begin
        mac_rdy_o = 1'b1;
        // Ack beats a same-cycle withdraw.
        if (mac_ack_i) begin
          ack_d = g_oh;
          cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
          if (ARB_MODE == 0) rr_d = nxt[GW-1:0];
          tmo_d   = '0;
          state_d = XFER;
        end else if (!cli_rdy_i[grant_q]) begin
          state_d = ARB;
        end
      end
      XFER: begin
        mac_rdy_o = 1'b1;
        cli_req_o = g_oh & {N_CH{mac_req_i}};
        tmo_d     = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST && !g_eof) begin
          mac_strm_o = ABORT_BEAT;
          abort_o    = 1'b1;
          state_d    = WAITD;
        end else begin
          mac_strm_o = strm_g;
          if (g_eof) state_d = WAITD;
        end
        // An early done from the MAC closes the frame outright.
        if (mac_done_i) begin
          done_d  = g_oh;
          gap_d   = '0;
          state_d = (GAP == 0) ? ARB : GAP_S;
        end
      end
      WAITD: begin
        if (mac_done_i) begin
          done_d  = g_oh;
          gap_d   = '0;
          state_d = (GAP == 0) ? ARB : GAP_S;
        end
      end
      GAP_S: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      grant_q <= '0;
      rr_q    <= '0;
      meta_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      for (int j = 0; j < N_CH; j++) cnt_q[j] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      meta_q  <= meta_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cli_ack_o   = ack_q;
  assign cli_done_o  = done_q;
  assign mac_meta_o  = meta_q;
  assign grant_idx_o = grant_q;

  for (genvar j = 0; j < N_CH; j++) begin : g_cnt
    assign grant_cnt_o[j*16 +: 16] = cnt_q[j];
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// tb_mac_tx_arb: self-checking bench for mac_tx_arb.
// Three instances share stimulus: rr, fixed priority, short timeout.
module tb_mac_tx_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   rdy;
  logic [47:0]  strm_in;
  logic [447:0] meta_in;
  logic         mreq, mack, mdone;

  logic [3:0]   o_req [3];
  logic [3:0]   o_ack [3];
  logic [3:0]   o_done [3];
  logic         o_rdy [3];
  logic [11:0]  o_strm [3];
  logic [111:0] o_meta [3];
  logic [1:0]   o_gidx [3];
  logic         o_abort [3];
  logic [63:0]  o_cnt [3];

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] cnt_m [3][4];
  int          rr_m [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    mac_tx_arb #(
      .N_CH(4), .ARB_MODE((g == 1) ? 1 : 0),
      .TIMEOUT((g == 2) ? 16 : 2048), .GAP(2), .META_W(112)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cli_rdy_i(rdy), .cli_strm_i(strm_in), .cli_meta_i(meta_in),
      .cli_req_o(o_req[g]), .cli_ack_o(o_ack[g]), .cli_done_o(o_done[g]),
      .mac_rdy_o(o_rdy[g]), .mac_strm_o(o_strm[g]), .mac_meta_o(o_meta[g]),
      .mac_req_i(mreq), .mac_ack_i(mack), .mac_done_i(mdone),
      .grant_idx_o(o_gidx[g]), .abort_o(o_abort[g]), .grant_cnt_o(o_cnt[g])
    );
  end

  typedef struct {
    int         inst;
    logic [3:0] rdy;
    int         len;
    int         exp_g;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [111:0] meta_of(int c);
    logic [47:0] dst;
    dst = (c == 2) ? 48'h112233445566 : 48'hDEAD00000000 + 48'(c);
    return {dst, 48'hA0A000000000 + 48'(c), 16'h0800 + 16'(c)};
  endfunction

  function automatic logic [11:0] beat(int c, int k, int len);
    return {8'(k * 3 + c * 50), 1'b1, k == 0, k == len - 1, 1'b0};
  endfunction

  function automatic logic [3:0] oh(int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  function automatic int mode_of(int inst);
    return (inst == 1) ? 1 : 0;
  endfunction

  // Reference arbiter: lowest ready index, or first ready index
  // found walking upward from the pointer with modulo wrap.
  function automatic int pick(int mode, logic [3:0] r, int rr);
    int res;
    res = -1;
    for (int k = 3; k >= 0; k--) begin
      if (mode == 1) begin
        if (r[k]) res = k;
      end else begin
        if (r[(rr + k) % 4]) res = (rr + k) % 4;
      end
    end
    return res;
  endfunction

  task automatic set_beats(int k, int len);
    for (int c = 0; c < 4; c++) strm_in[c*12 +: 12] = beat(c, k, len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = '0; strm_in = '0; mreq = 0; mack = 0; mdone = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rr_m[i] = 0;
      for (int c = 0; c < 4; c++) cnt_m[i][c] = '0;
    end
  endtask

  task automatic chk_idle(int i, string tag);
    chk({tag, "_rdy"}, 128'(o_rdy[i]), 128'(0));
    chk({tag, "_strm"}, 128'(o_strm[i]), 128'(0));
    chk({tag, "_meta"}, 128'(o_meta[i]), 128'(0));
    chk({tag, "_gidx"}, 128'(o_gidx[i]), 128'(0));
    chk({tag, "_hs"}, 128'({o_req[i], o_ack[i], o_done[i]}), 128'(0));
    chk({tag, "_abort"}, 128'(o_abort[i]), 128'(0));
    chk({tag, "_cnt"}, 128'(o_cnt[i]), 128'(0));
  endtask

  task automatic wait_rdy(int inst);
    int n;
    n = 0;
    while (!o_rdy[inst] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_up", 128'(o_rdy[inst]), 128'(1));
  endtask

  // Full handshake for one frame; called on a falling edge.
  task automatic do_frame(int inst, int len, int expg);
    wait_rdy(inst);
    chk("grant", 128'(o_gidx[inst]), 128'(expg));
    chk("meta", 128'(o_meta[inst]), 128'(meta_of(expg)));
    mack = 1'b1;
    @(negedge clk);
    mack = 1'b0;
    chk("cli_ack", 128'(o_ack[inst]), 128'(oh(expg)));
    cnt_m[inst][expg] = cnt_m[inst][expg] + 16'd1;
    if (mode_of(inst) == 0) rr_m[inst] = (expg + 1) % 4;
    chk("gcnt", 128'(o_cnt[inst][expg*16 +: 16]), 128'(cnt_m[inst][expg]));
    for (int k = 0; k < len; k++) begin
      set_beats(k, len);
      mreq = 1'b1;
      #1;
      chk("strm", 128'(o_strm[inst]), 128'(beat(expg, k, len)));
      if (k == 0) chk("cli_req", 128'(o_req[inst]), 128'(oh(expg)));
      @(negedge clk);
    end
    strm_in = '0;
    mreq = 1'b0;
    #1;
    chk("waitd_rdy", 128'(o_rdy[inst]), 128'(0));
    @(negedge clk);
    mdone = 1'b1;
    @(negedge clk);
    mdone = 1'b0;
    chk("cli_done", 128'(o_done[inst]), 128'(oh(expg)));
    chk("gap_rdy0", 128'(o_rdy[inst]), 128'(0));
    @(negedge clk);
    chk("gap_rdy1", 128'(o_rdy[inst]), 128'(0));
  endtask

  initial begin
    int aborts;
    logic [11:0] exp_b;
    logic [3:0] r;
    int inst;

    for (int i = 0; i < 8; i++) tbl[i] = '{0, 4'hF, 3, i % 4};
    for (int i = 8; i < 12; i++) tbl[i] = '{1, 4'b1010, 2, 1};
    for (int c = 0; c < 4; c++) meta_in[c*112 +: 112] = meta_of(c);

    // Reset values
    do_reset();
    chk_idle(0, "reset");

    // Single channel, 64-byte frame
    chk("arb_rdy0", 128'(o_rdy[0]), 128'(0));
    rdy = 4'b0100;
    @(negedge clk);
    chk("rdy_1cyc", 128'(o_rdy[0]), 128'(1));
    chk("meta_dst", 128'(o_meta[0][111:64]), 128'(48'h112233445566));
    do_frame(0, 64, 2);
    chk("single_cnt", 128'(o_cnt[0][2*16 +: 16]), 128'(16'd1));

    // Round-robin table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rdy = tbl[i].rdy;
      do_frame(tbl[i].inst, tbl[i].len, tbl[i].exp_g);
    end
    for (int c = 0; c < 4; c++)
      chk("rr_cnt", 128'(o_cnt[0][c*16 +: 16]), 128'(16'd2));

    // Fixed priority table
    do_reset();
    for (int i = 8; i < 12; i++) begin
      rdy = tbl[i].rdy;
      do_frame(tbl[i].inst, tbl[i].len, tbl[i].exp_g);
    end
    chk("prio_cnt1", 128'(o_cnt[1][1*16 +: 16]), 128'(16'd4));
    chk("prio_cnt3", 128'(o_cnt[1][3*16 +: 16]), 128'(16'd0));

    // Withdraw before ack
    do_reset();
    rdy = 4'b0001;
    @(negedge clk);
    chk("wd_rdy_up", 128'(o_rdy[0]), 128'(1));
    rdy = 4'b0000;
    @(negedge clk);
    chk("wd_rdy_dn", 128'(o_rdy[0]), 128'(0));
    chk("wd_ack", 128'(o_ack[0]), 128'(0));
    chk("wd_cnt", 128'(o_cnt[0][15:0]), 128'(0));
    rdy = 4'hF;
    do_frame(0, 2, pick(0, 4'hF, rr_m[0]));

    // Timeout abort on the short-timeout instance
    do_reset();
    rdy = 4'b0001;
    wait_rdy(2);
    chk("tmo_grant", 128'(o_gidx[2]), 128'(0));
    mack = 1'b1;
    @(negedge clk);
    mack = 1'b0;
    aborts = 0;
    for (int k = 0; k < 21; k++) begin
      for (int c = 0; c < 4; c++)
        strm_in[c*12 +: 12] = {8'(k), 1'b1, k == 0, 1'b0, 1'b0};
      mreq = 1'b1;
      #1;
      if (k < 15) exp_b = {8'(k), 1'b1, k == 0, 1'b0, 1'b0};
      else if (k == 15) exp_b = 12'h00B;
      else exp_b = 12'h000;
      chk("tmo_strm", 128'(o_strm[2]), 128'(exp_b));
      if (k == 15) chk("tmo_abort", 128'(o_abort[2]), 128'(1));
      aborts += int'(o_abort[2]);
      @(negedge clk);
    end
    chk("tmo_abort_cnt", 128'(aborts), 128'(1));
    strm_in = '0;
    mreq = 1'b0;
    mdone = 1'b1;
    @(negedge clk);
    mdone = 1'b0;
    chk("tmo_done", 128'(o_done[2]), 128'(4'b0001));

    // Async reset mid-transfer
    do_reset();
    rdy = 4'b0001;
    do_frame(0, 2, 0);
    rdy = 4'b0010;
    wait_rdy(0);
    mack = 1'b1;
    @(negedge clk);
    mack = 1'b0;
    set_beats(0, 8);
    mreq = 1'b1;
    @(negedge clk);
    set_beats(1, 8);
    #2;
    rst = 1'b1;
    #1;
    chk_idle(0, "arst");
    @(negedge clk);
    rst = 1'b0;
    strm_in = '0; mreq = 0;
    for (int c = 0; c < 4; c++) cnt_m[0][c] = '0;
    rr_m[0] = 0;
    rdy = 4'hF;
    do_frame(0, 2, pick(0, 4'hF, rr_m[0]));

    // Random masks against the reference arbiter
    for (int it = 0; it < 24; it++) begin
      if (it == 0 || it == 12) do_reset();
      inst = (it < 12) ? 0 : 1;
      r = 4'($urandom_range(1, 15));
      rdy = r;
      do_frame(inst, int'($urandom_range(1, 5)), pick(mode_of(inst), r, rr_m[inst]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_tx_arb.md
Name: mac_tx_arb

Overview:
- N-channel transmit arbiter placed between upper-layer TX sources (ipv4, arp, raw) and the single MAC TX engine.
- Each client side uses the MAC TX handshake (rdy/req/ack/done plus stream and meta). The arbiter presents one merged handshake to the MAC.
- Generalises the point-to-point MAC handshake to N_CH channels with selectable arbitration, stall timeout abort, and a per-channel grant counter.

Parameters:
N_CH, 4, number of client channels (2..8)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
TIMEOUT, 2048, max cycles from grant to stream eof before forced abort
GAP, 2, idle cycles enforced after mac_done before next arbitration

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cli_rdy  in  N_CH  client has frame pending; its meta is valid
cli_strm  in  N_CH x stream_t  client stream (dat[7:0], val, sof, eof, err)
cli_meta  in  N_CH x mac_meta_t  client MAC header
cli_req  out  N_CH  MAC data request forwarded to the granted client only
cli_ack  out  N_CH  one-cycle grant acknowledge to the granted client
cli_done  out  N_CH  one-cycle frame-complete pulse to the granted client
mac_rdy  out  1  merged ready to MAC TX
mac_strm  out  stream_t  muxed stream to MAC TX
mac_meta  out  mac_meta_t  latched meta of granted client
mac_req  in  1  MAC requests stream data
mac_ack  in  1  MAC accepted frame
mac_done  in  1  MAC finished frame
grant_idx  out  $clog2(N_CH)  currently or last granted channel
abort  out  1  one-cycle pulse on timeout abort
grant_cnt  out  N_CH x 16  per-channel grant counters, wrapping

Behaviour:
- Reset values: all outputs 0; mac_meta 0; rr pointer 0; state ARB.
- ARB state:
  - If any cli_rdy is high, select a winner:
    - Mode 0: first set bit searching upward from rr pointer, wrapping at N_CH-1 to 0.
    - Mode 1: lowest index set.
  - Register grant_idx and latch cli_meta[winner] into mac_meta in the same edge; go to OFFER.
  - Selection to mac_rdy high takes 1 cycle.
- OFFER state:
  - mac_rdy=1.
  - If cli_rdy[grant] drops before mac_ack: mac_rdy low next cycle, return to ARB, rr pointer unchanged, no counter increment.
  - On mac_ack: cli_ack[grant] pulses for 1 cycle (registered, 1 cycle after mac_ack); grant_cnt[grant] += 1 (wraps 0xFFFF->0). In mode 0, rr pointer = grant+1 mod N_CH. Go to XFER.
  - mac_ack and cli_rdy drop in the same cycle: ack wins.
- XFER state:
  - cli_req[grant] = mac_req (combinational); other cli_req stay 0.
  - mac_strm = cli_strm[grant] (combinational, zero latency).
  - mac_rdy stays 1 until the eof beat is seen, then 0.
  - Timeout counter starts at 0 on entry and increments each cycle until eof.
  - If the counter reaches TIMEOUT-1 without eof: drive one beat mac_strm = {dat 0, val 1, sof 0, eof 1, err 1}; abort pulses; all subsequent client beats are masked (mac_strm.val=0); go to WAITD.
  - On normal eof: go to WAITD.
- WAITD state:
  - mac_strm held 0.
  - On mac_done: cli_done[grant] pulses 1 cycle (registered); go to GAP.
  - mac_done arriving during XFER (early) is honoured the same way and ends the transfer.
- GAP state: count GAP cycles with all outputs idle (mac_rdy 0), then ARB. GAP=0 means go directly to ARB.
- Non-granted clients: req/ack/done always 0; their strm is ignored.
- Reset mid-frame: asynchronous return to reset values. A partial frame is not completed; the MAC is responsible for its own recovery.
- Counter widths: timeout counter $clog2(TIMEOUT+1) bits; GAP counter $clog2(GAP+1) bits.

Test Plan:
- Single channel: cli_rdy[2]=1, meta dst=0x112233445566. Required: mac_rdy rises 1 cycle later with that meta. mac_ack -> cli_ack[2] pulses next cycle, grant_cnt[2]=1. A 64-byte frame passes unchanged. mac_done -> cli_done[2] pulse. mac_rdy stays low for 2 cycles after done.
- Round-robin, mode 0, all four cli_rdy held high for 8 frames. Required grant order 0,1,2,3,0,1,2,3; each grant_cnt=2.
- Priority, mode 1, cli_rdy=4'b1010 held. Required: channel 1 granted every time, channel 3 starved, grant_cnt[3]=0.
- Withdraw: cli_rdy[0] drops in OFFER before mac_ack. Required: mac_rdy low next cycle, no cli_ack, grant_cnt[0] unchanged, rr pointer still 0.
- Timeout: TIMEOUT=16, client sends sof and then never eof. Required: at cycle 15 of XFER, mac_strm emits eof=1 err=1; abort pulses once; later client beats masked; cli_done on mac_done.
- Async reset asserted mid-XFER. Required: all outputs 0 immediately; after release, state ARB and rr pointer 0.
